// File: rtl/refresh_scoreboard.sv
// Refresh sweep scoreboard: walks every row once per sweep, skipping rows already written or refreshed on demand.
// ref_addr/ref_valid are combinational from state and user inputs; a stalled ref_ready holds ptr, the request is not sticky.
module refresh_scoreboard #(
    parameter int ROWS       = 128,
    parameter int AW         = $clog2(ROWS),
    parameter int RET_CYCLES = 4096
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          user_we,
    input  logic [AW-1:0] user_waddr,
    input  logic          user_re,
    input  logic [AW-1:0] user_raddr,
    input  logic          ref_ready,
    output logic          ref_valid,
    output logic [AW-1:0] ref_addr,
    output logic          indicator_user,
    output logic          busy,
    output logic          done,
    output logic          overrun
);

    localparam int            TW       = (RET_CYCLES > 1) ? $clog2(RET_CYCLES) : 1;
    localparam logic [TW-1:0] TMR_LAST = TW'(RET_CYCLES - 1);
    localparam logic [AW-1:0] PTR_LAST = AW'(ROWS - 1);
    localparam logic [AW:0]   ROWS_EXT = (AW + 1)'(ROWS);

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t          state;
    logic [ROWS-1:0] sb;
    logic [AW-1:0]   ptr;
    logic [TW-1:0]   tmr;

    logic trigger;
    logic in_sweep;
    logic raddr_ok;
    logic waddr_ok;
    logic sb_rd;
    logic sb_ptr;
    logic prio;
    logic hs;
    logic advance;

    assign trigger  = (tmr == TMR_LAST);
    assign in_sweep = (state == SWEEP);
    assign raddr_ok = ({1'b0, user_raddr} < ROWS_EXT);
    assign waddr_ok = ({1'b0, user_waddr} < ROWS_EXT);

    // Out-of-range read rows are masked so they never look stale or fresh.
    assign sb_rd  = raddr_ok ? sb[user_raddr] : 1'b0;
    assign sb_ptr = sb[ptr];

    // A user read of a not-yet-refreshed row jumps ahead of the sweep pointer.
    assign prio      = in_sweep && user_re && raddr_ok && !sb_rd;
    assign ref_addr  = prio ? user_raddr : (in_sweep ? ptr : '0);
    assign ref_valid = in_sweep && (prio || !sb_ptr);
    assign hs        = ref_valid && ref_ready;
    assign advance   = in_sweep && (sb_ptr || (hs && (ref_addr == ptr)));

    assign indicator_user = !raddr_ok ? 1'b0 : (in_sweep ? sb_rd : 1'b1);
    assign busy           = in_sweep;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            sb      <= '0;
            ptr     <= '0;
            tmr     <= '0;
            done    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            // Retention timer is free-running; sweeps never re-phase it.
            tmr  <= trigger ? '0 : tmr + TW'(1);
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start || trigger) begin
                        state <= SWEEP;
                        sb    <= '0;
                        ptr   <= '0;
                    end
                end
                SWEEP: begin
                    if (trigger) begin
                        overrun <= 1'b1;
                    end
                    if (hs) begin
                        sb[ref_addr] <= 1'b1;
                    end
                    if (user_we && waddr_ok) begin
                        sb[user_waddr] <= 1'b1;
                    end
                    if (advance) begin
                        if (ptr == PTR_LAST) begin
                            state <= IDLE;
                            ptr   <= '0;
                            done  <= 1'b1;
                        end else begin
                            ptr <= ptr + AW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_refresh_scoreboard.sv
// Bench for refresh_scoreboard with ROWS=8, RET_CYCLES=64; inputs change on negedge, outputs sampled 1ns later.
module tb_refresh_scoreboard;

    localparam int ROWS = 8;
    localparam int AW   = 3;
    localparam int RET  = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          user_we = 1'b0;
    logic [AW-1:0] user_waddr = '0;
    logic          user_re = 1'b0;
    logic [AW-1:0] user_raddr = '0;
    logic          ref_ready = 1'b0;
    logic          ref_valid;
    logic [AW-1:0] ref_addr;
    logic          indicator_user;
    logic          busy;
    logic          done;
    logic          overrun;

    refresh_scoreboard #(.ROWS(ROWS), .AW(AW), .RET_CYCLES(RET)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .user_we        (user_we),
        .user_waddr     (user_waddr),
        .user_re        (user_re),
        .user_raddr     (user_raddr),
        .ref_ready      (ref_ready),
        .ref_valid      (ref_valid),
        .ref_addr       (ref_addr),
        .indicator_user (indicator_user),
        .busy           (busy),
        .done           (done),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    // exp packs {ref_valid, ref_addr[2:0], indicator_user, busy, done, overrun}
    typedef struct {
        string      name;
        logic       st;
        logic       we;
        logic [2:0] wa;
        logic       re;
        logic [2:0] ra;
        logic       rdy;
        logic [7:0] exp;
    } vec_t;

    logic [7:0] exp_q[$];
    string      name_q[$];
    int         n_vec = 0;
    int         n_bad = 0;
    vec_t       tbl[11];

    function automatic vec_t mkv(string n, int st, int we, int wa, int re, int ra, int rdy,
                                 int ev, int ea, int ei, int eb, int ed, int eo);
        vec_t v;
        v.name = n;
        v.st   = st[0];
        v.we   = we[0];
        v.wa   = wa[2:0];
        v.re   = re[0];
        v.ra   = ra[2:0];
        v.rdy  = rdy[0];
        v.exp  = {ev[0], ea[2:0], ei[0], eb[0], ed[0], eo[0]};
        return v;
    endfunction

    task automatic push_exp(input string n, input logic [7:0] e);
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    task automatic check_pop();
        logic [7:0] e;
        logic [7:0] a;
        string      n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        a = {ref_valid, ref_addr, indicator_user, busy, done, overrun};
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s @%0t: got %b need %b (valid,addr,ind,busy,done,ovr)", n, $time, a, e);
        end
    endtask

    task automatic drive_check(input vec_t v);
        start      = v.st;
        user_we    = v.we;
        user_waddr = v.wa;
        user_re    = v.re;
        user_raddr = v.ra;
        ref_ready  = v.rdy;
        push_exp(v.name, v.exp);
        #1;
        check_pop();
    endtask

    task automatic apply(input vec_t v);
        drive_check(v);
        @(negedge clk);
    endtask

    // Holds reset across two edges with busy inputs, then releases it on a negedge.
    task automatic do_reset();
        rst        = 1'b0;
        start      = 1'b1;
        ref_ready  = 1'b1;
        user_we    = 1'b1;
        user_waddr = 3'd5;
        user_re    = 1'b1;
        user_raddr = 3'd3;
        push_exp("reset_now", 8'b0000_1000);
        #1;
        check_pop();
        repeat (2) @(negedge clk);
        push_exp("reset_hold", 8'b0000_1000);
        #1;
        check_pop();
        @(negedge clk);
        start      = 1'b0;
        ref_ready  = 1'b0;
        user_we    = 1'b0;
        user_waddr = '0;
        user_re    = 1'b0;
        user_raddr = '0;
        rst        = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, need finish before 100000ns");
        $fatal(1, "watchdog");
    end

    initial begin
        // Manual sweep with ref_ready held; start re-asserted mid-sweep must be ignored.
        tbl[0] = mkv("b_start", 1, 0, 0, 0, 7, 1, 0, 0, 1, 0, 0, 0);
        for (int k = 1; k <= 8; k++)
            tbl[k] = mkv("b_sweep", (k == 4), 0, 0, 0, 7, 1, 1, k - 1, 0, 1, 0, 0);
        tbl[9]  = mkv("b_done", 0, 0, 0, 0, 7, 1, 0, 0, 1, 0, 1, 0);
        tbl[10] = mkv("b_after", 0, 0, 0, 0, 7, 1, 0, 0, 1, 0, 0, 0);

        do_reset();
        for (int i = 0; i < 11; i++) apply(tbl[i]);

        // Rows 2 and 3 written ahead of the pointer are skipped without a request.
        do_reset();
        apply(mkv("c_start", 1, 0, 0, 0, 7, 1, 0, 0, 1, 0, 0, 0));
        apply(mkv("c_we2",   0, 1, 2, 0, 7, 1, 1, 0, 0, 1, 0, 0));
        apply(mkv("c_we3",   0, 1, 3, 0, 7, 1, 1, 1, 0, 1, 0, 0));
        apply(mkv("c_skip2", 0, 0, 0, 0, 7, 1, 0, 2, 0, 1, 0, 0));
        apply(mkv("c_skip3", 0, 0, 0, 0, 7, 1, 0, 3, 0, 1, 0, 0));
        for (int k = 4; k <= 7; k++)
            apply(mkv("c_sweep", 0, 0, 0, 0, 7, 1, 1, k, 0, 1, 0, 0));
        apply(mkv("c_done",  0, 0, 0, 0, 7, 1, 0, 0, 1, 0, 1, 0));

        // User read of row 6 at ptr=1 jumps the queue; ptr later skips row 6.
        do_reset();
        apply(mkv("d_start", 1, 0, 0, 0, 7, 1, 0, 0, 1, 0, 0, 0));
        apply(mkv("d_ptr0",  0, 0, 0, 0, 7, 1, 1, 0, 0, 1, 0, 0));
        apply(mkv("d_prio",  0, 0, 0, 1, 6, 1, 1, 6, 0, 1, 0, 0));
        apply(mkv("d_fresh", 0, 0, 0, 0, 6, 1, 1, 1, 1, 1, 0, 0));
        for (int k = 2; k <= 5; k++)
            apply(mkv("d_sweep", 0, 0, 0, 0, 6, 1, 1, k, 1, 1, 0, 0));
        apply(mkv("d_skip6", 0, 0, 0, 0, 6, 1, 0, 6, 1, 1, 0, 0));
        apply(mkv("d_row7",  0, 0, 0, 0, 6, 1, 1, 7, 1, 1, 0, 0));
        apply(mkv("d_done",  0, 0, 0, 0, 6, 1, 0, 0, 1, 0, 1, 0));

        // No traffic, ref_ready low: idle until the timer wraps, then stall and overrun.
        do_reset();
        for (int k = 0; k < 140; k++)
            apply(mkv((k < 64) ? "e_idle" : ((k < 128) ? "e_stall" : "e_ovr"),
                      0, 0, 0, 0, 0, 0, (k >= 64), 0, (k < 64), (k >= 64), 0, (k >= 128)));

        // Reset mid-sweep at ptr=4 drops everything at once; next sweep restarts at row 0.
        do_reset();
        apply(mkv("f_start", 1, 0, 0, 0, 7, 1, 0, 0, 1, 0, 0, 0));
        for (int k = 0; k <= 3; k++)
            apply(mkv("f_sweep", 0, 0, 0, 0, 7, 1, 1, k, 0, 1, 0, 0));
        drive_check(mkv("f_ptr4", 0, 0, 0, 0, 7, 1, 1, 4, 0, 1, 0, 0));
        #1;
        rst = 1'b0;
        push_exp("f_rst_async", 8'b0000_1000);
        #1;
        check_pop();
        @(negedge clk);
        rst = 1'b1;
        apply(mkv("f_idle",  0, 0, 0, 0, 7, 1, 0, 0, 1, 0, 0, 0));
        apply(mkv("f_start2", 1, 0, 0, 0, 7, 1, 0, 0, 1, 0, 0, 0));
        apply(mkv("f_row0",  0, 0, 0, 0, 7, 1, 1, 0, 0, 1, 0, 0));
        apply(mkv("f_row1",  0, 0, 0, 0, 7, 1, 1, 1, 0, 1, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/refresh_scoreboard.md
REFRESH_SCOREBOARD -- requirements
Module: refresh_scoreboard

Interface
REQ-001 SHALL have parameter ROWS, default 128: number of array rows tracked (ROWS >= 2).
REQ-002 SHALL have parameter AW, default $clog2(ROWS): row address width.
REQ-003 SHALL have parameter RET_CYCLES, default 4096: retention interval in clk cycles (>= 2*ROWS).
REQ-004 SHALL have ports:
  clk  in  1  clock; rising-edge.
  rst  in  1  asynchronous, active-low reset.
  start  in  1  manual sweep request.
  user_we  in  1  user row write.
  user_waddr  in  AW  user write row.
  user_re  in  1  user row read.
  user_raddr  in  AW  user read row.
  ref_ready  in  1  array accepts refresh this cycle.
  ref_valid  out  1  refresh request valid.
  ref_addr  out  AW  row to refresh.
  indicator_user  out  1  row user_raddr is fresh in the current sweep.
  busy  out  1  sweep in progress.
  done  out  1  one-cycle sweep-complete pulse.
  overrun  out  1  sticky retention-overrun flag.

Function
REQ-005 SHALL use a two-state FSM: IDLE and SWEEP.
REQ-006 SHALL hold a ROWS-bit scoreboard sb, a row pointer ptr (AW bits) and a retention timer tmr.
REQ-007 tmr SHALL count every cycle in both states, wrap from RET_CYCLES-1 to 0, and assert an internal trigger on that wrap cycle.
REQ-008 IDLE -> SWEEP SHALL occur on the edge where start or trigger is high; start and trigger together SHALL give one sweep.
REQ-009 On entry to SWEEP, sb SHALL clear to all-zero and ptr SHALL be 0.
REQ-010 In SWEEP, start SHALL be ignored; a trigger SHALL set overrun, which is cleared only by rst.
REQ-011 In SWEEP, priority SHALL be user_re && user_raddr < ROWS && !sb[user_raddr].
REQ-012 ref_addr SHALL be user_raddr under priority, else ptr (combinational); in IDLE ref_addr SHALL be 0.
REQ-013 ref_valid SHALL be high in SWEEP under priority or when !sb[ptr]; otherwise low.
REQ-014 ref_addr MAY change while ref_valid=1 and ref_ready=0; the requester is not sticky.
REQ-015 On ref_valid && ref_ready, sb[ref_addr] SHALL be set at the clock edge.
REQ-016 In SWEEP, user_we with user_waddr < ROWS SHALL set sb[user_waddr]; out-of-range addresses SHALL be ignored.
REQ-017 The write and the handshake in REQ-015 and REQ-016 MAY hit the same or different rows in one cycle; both SHALL be set.
REQ-018 ptr SHALL increment when sb[ptr]=1 (skip, no request issued) or when a handshake occurs with ref_addr==ptr; otherwise it SHALL hold.
REQ-019 When ptr==ROWS-1 and it would increment, the FSM SHALL go to IDLE instead of incrementing ptr, and done SHALL be 1 for the following cycle only.
REQ-020 indicator_user SHALL be 1 in IDLE, sb[user_raddr] in SWEEP, and 0 when user_raddr >= ROWS.
REQ-021 busy SHALL equal (state==SWEEP).
REQ-022 tmr SHALL not be reset by start or by sweep completion.

Reset
REQ-023 rst=0 SHALL asynchronously force the following: state IDLE, ptr 0, tmr 0, sb all-zero, done 0, overrun 0, ref_valid 0, ref_addr 0, busy 0, indicator_user 1.
REQ-024 Reset asserted mid-sweep SHALL abandon the sweep without a done pulse; the next sweep SHALL begin at row 0.

Verification (ROWS=8, RET_CYCLES=64)
REQ-025 Release reset with start=0 and no traffic -> all outputs at REQ-023 values until cycle 64, then busy=1.
REQ-026 Pulse start, hold ref_ready=1, no user traffic -> ref_addr 0..7 on 8 consecutive cycles, busy high 8 cycles, done=1 on the 9th cycle.
REQ-027 Write rows 2 and 3 before ptr reaches them -> ref_valid=0 for one cycle each at ptr=2 and ptr=3, no refresh issued for those rows, done still fires.
REQ-028 At ptr=1 with ref_ready=1, user_re=1 and user_raddr=6 -> ref_addr=6 and indicator_user=0 that cycle, indicator_user=1 the next cycle; ptr later skips row 6.
REQ-029 Hold ref_ready=0 -> sweep auto-starts at cycle 64, ptr stalls at 0, overrun=1 at cycle 128 and stays 1.
REQ-030 Drive rst=0 at ptr=4 -> busy, ref_valid and ptr drop immediately; after release, start -> ref_addr begins at 0.
